// File: rtl/core_ctrl_pkg.sv
// Shared types and helpers for the per-core tile sequencer.
package core_ctrl_pkg;

  localparam int unsigned DEF_GBUS_ADDR  = 12;
  localparam int unsigned DEF_LBUF_DEPTH = 16;
  localparam int unsigned DEF_CDATA_BIT  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_COMP,
    ST_NEXT,
    ST_FLUSH,
    ST_DONE
  } state_e;

  // A job is runnable only if every output fits in the buffer and there is work to do.
  function automatic logic cfg_ok(input int unsigned acc_num,
                                  input int unsigned out_num,
                                  input int unsigned depth);
    return (acc_num != 0) && (acc_num <= depth) && (out_num != 0);
  endfunction

endpackage

// File: rtl/core_ctrl_if.sv
// Control bundle between the global controller, core_ctrl and the core datapath ports.
interface core_ctrl_if
  import core_ctrl_pkg::*;
#(
  parameter int unsigned GBUS_ADDR  = DEF_GBUS_ADDR,
  parameter int unsigned LBUF_DEPTH = DEF_LBUF_DEPTH,
  parameter int unsigned LBUF_ADDR  = $clog2(LBUF_DEPTH),
  parameter int unsigned CDATA_BIT  = DEF_CDATA_BIT
);

  logic                 start;
  logic [GBUS_ADDR-1:0] cfg_base_addr;
  logic [CDATA_BIT-1:0] cfg_acc_num;
  logic [CDATA_BIT-1:0] cfg_out_num;
  logic                 cfg_wb_en;
  logic [GBUS_ADDR-1:0] cfg_wb_addr;
  logic                 core_odata_valid;

  logic                 busy;
  logic                 done;
  logic                 err;
  logic [GBUS_ADDR-1:0] cmem_raddr;
  logic                 cmem_ren;
  logic [GBUS_ADDR-1:0] cmem_waddr;
  logic                 cmem_wen;
  logic [LBUF_ADDR-1:0] lbuf_waddr;
  logic [LBUF_ADDR-1:0] lbuf_raddr;
  logic [LBUF_ADDR-1:0] abuf_raddr;
  logic                 lbuf_ren;
  logic                 abuf_ren;

  modport master (
    output start, cfg_base_addr, cfg_acc_num, cfg_out_num, cfg_wb_en, cfg_wb_addr,
           core_odata_valid,
    input  busy, done, err, cmem_raddr, cmem_ren, cmem_waddr, cmem_wen,
           lbuf_waddr, lbuf_raddr, abuf_raddr, lbuf_ren, abuf_ren
  );

  modport slave (
    input  start, cfg_base_addr, cfg_acc_num, cfg_out_num, cfg_wb_en, cfg_wb_addr,
           core_odata_valid,
    output busy, done, err, cmem_raddr, cmem_ren, cmem_waddr, cmem_wen,
           lbuf_waddr, lbuf_raddr, abuf_raddr, lbuf_ren, abuf_ren
  );

endinterface

// File: rtl/core_ctrl_dly.sv
// Fixed-latency shift register aligning the load beat index with returning memory data.
module core_ctrl_dly #(
  parameter int unsigned W   = 4,
  parameter int unsigned LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  if (LAT == 0) begin : g_bypass
    assign o_q = i_d;
  end else begin : g_pipe
    logic [W-1:0] r_pipe [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < LAT; i++) r_pipe[i] <= '0;
      end else begin
        r_pipe[0] <= i_d;
        for (int unsigned i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end

    assign o_q = r_pipe[LAT-1];
  end

endmodule

// File: rtl/core_ctrl.sv
// Per-core sequencer: loads one row per output into LBUF, streams LBUF/ABUF reads, tracks KV write-back.
module core_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int unsigned GBUS_ADDR  = DEF_GBUS_ADDR,
  parameter int unsigned LBUF_DEPTH = DEF_LBUF_DEPTH,
  parameter int unsigned LBUF_ADDR  = $clog2(LBUF_DEPTH),
  parameter int unsigned CDATA_BIT  = DEF_CDATA_BIT,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned PIPE_LAT   = 8
) (
  input  logic       clk,
  input  logic       rst,
  core_ctrl_if.slave bus
);

  localparam int unsigned WAIT_W = $clog2(MEM_LAT + PIPE_LAT + 2);

  state_e               r_state, w_next;
  logic [GBUS_ADDR-1:0] r_rptr;
  logic [GBUS_ADDR-1:0] r_waddr;
  logic [CDATA_BIT-1:0] r_acc;
  logic [CDATA_BIT-1:0] r_outnum;
  logic [CDATA_BIT-1:0] r_out;
  logic [CDATA_BIT-1:0] r_beat;
  logic [WAIT_W-1:0]    r_wait;
  logic                 r_wb_en;
  logic                 r_err;

  logic                 w_start_ok;
  logic                 w_cfg_ok;
  logic                 w_beat_last;
  logic                 w_mem_last;
  logic                 w_pipe_last;
  logic                 w_out_last;
  logic                 w_busy;
  logic [LBUF_ADDR-1:0] w_lbuf_waddr;

  assign w_start_ok  = (r_state == ST_IDLE) && bus.start;
  assign w_cfg_ok    = cfg_ok(32'(bus.cfg_acc_num), 32'(bus.cfg_out_num), LBUF_DEPTH);
  assign w_beat_last = (CDATA_BIT'(r_beat + 1'b1) == r_acc);
  assign w_mem_last  = ((32'(r_wait) + 32'd1) == MEM_LAT);
  assign w_pipe_last = ((32'(r_wait) + 32'd1) == PIPE_LAT);
  assign w_out_last  = (CDATA_BIT'(r_out + 1'b1) == r_outnum);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start) w_next = w_cfg_ok ? ST_LOAD : ST_DONE;
      ST_LOAD:  if (w_beat_last) w_next = (MEM_LAT == 0) ? ST_COMP : ST_DRAIN;
      ST_DRAIN: if (w_mem_last) w_next = ST_COMP;
      ST_COMP:  if (w_beat_last) w_next = ST_NEXT;
      ST_NEXT: begin
        if (!w_out_last)        w_next = ST_LOAD;
        else if (PIPE_LAT == 0) w_next = ST_DONE;
        else                    w_next = ST_FLUSH;
      end
      ST_FLUSH: if (w_pipe_last) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_rptr   <= '0;
      r_waddr  <= '0;
      r_acc    <= '0;
      r_outnum <= '0;
      r_out    <= '0;
      r_beat   <= '0;
      r_wait   <= '0;
      r_wb_en  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;

      if (w_start_ok) begin
        r_acc    <= bus.cfg_acc_num;
        r_outnum <= bus.cfg_out_num;
        r_wb_en  <= bus.cfg_wb_en;
        r_rptr   <= bus.cfg_base_addr;
        r_waddr  <= bus.cfg_wb_addr;
        r_err    <= !w_cfg_ok;
        r_out    <= '0;
      end else begin
        // Row pointer runs across outputs so output j reads base + j*acc_num + k.
        if (r_state == ST_LOAD) r_rptr <= r_rptr + 1'b1;
        if ((r_state != ST_IDLE) && bus.core_odata_valid) r_waddr <= r_waddr + 1'b1;
        if (r_state == ST_NEXT) r_out <= r_out + 1'b1;
      end

      if ((r_state == ST_LOAD) || (r_state == ST_COMP))
        r_beat <= w_beat_last ? '0 : r_beat + 1'b1;
      else
        r_beat <= '0;

      if (((r_state == ST_DRAIN) && !w_mem_last) || ((r_state == ST_FLUSH) && !w_pipe_last))
        r_wait <= r_wait + 1'b1;
      else
        r_wait <= '0;
    end
  end

  core_ctrl_dly #(
    .W   (LBUF_ADDR),
    .LAT (MEM_LAT)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst),
    .i_d   (r_beat[LBUF_ADDR-1:0]),
    .o_q   (w_lbuf_waddr)
  );

  assign w_busy = (r_state != ST_IDLE) && (r_state != ST_DONE);

  assign bus.busy       = w_busy;
  assign bus.done       = (r_state == ST_DONE);
  assign bus.err        = r_err;
  assign bus.cmem_ren   = (r_state == ST_LOAD);
  assign bus.cmem_raddr = r_rptr;
  assign bus.cmem_wen   = w_busy & r_wb_en;
  assign bus.cmem_waddr = r_waddr;
  assign bus.lbuf_waddr = w_lbuf_waddr;
  assign bus.lbuf_ren   = (r_state == ST_COMP);
  assign bus.abuf_ren   = (r_state == ST_COMP);
  assign bus.lbuf_raddr = r_beat[LBUF_ADDR-1:0];
  assign bus.abuf_raddr = r_beat[LBUF_ADDR-1:0];

endmodule
